// File: rtl/jeff_alu_sliced_pkg.sv
// Shared definitions for jeff_alu_sliced: slice width, FSM states and
// named '181 function-select codes.
package jeff_alu_sliced_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Function selects (active-high data). S_XOR is meaningful with m=1.
  localparam logic [3:0] S_ADD    = 4'b1001;
  localparam logic [3:0] S_SUB_M1 = 4'b0110;
  localparam logic [3:0] S_XOR    = 4'b0110;

endpackage

// File: rtl/jeff_alu_sliced_slice.sv
// Combinational 4-bit '181-equivalent slice (active-high data, active-low
// carries at the boundary). c3 is the active-high carry into bit 3, used
// for signed overflow when JEFF_ALU_SLICED_OVF_EN is defined at the top.
module alu_slice_4bit
  import jeff_alu_sliced_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cin_n,
  output logic [3:0] f,
  output logic       cout_n,
  output logic       c3
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;

  // '181 internal terms: w_p is the "propagate" word, w_g the "generate"
  // word; arithmetic result is w_p + w_g + carry, logic is ~(w_p ^ w_g).
  always_comb begin
    w_p = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    w_g = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    w_c = '0;
    w_c[0] = ~cin_n;
    for (int i = 0; i < SLICE_W; i++) begin
      w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end
    f      = w_p ^ w_g ^ (m ? 4'hF : w_c[3:0]);
    cout_n = ~w_c[4];
    c3     = w_c[3];
  end

endmodule

// File: rtl/jeff_alu_sliced.sv
// Multi-cycle WIDTH-bit '181-style ALU: one 4-bit slice per clock, LSB
// slice first, carry rippled through a register.
// Optional: define JEFF_ALU_SLICED_OVF_EN to add the signed-overflow
// output ovf.
module jeff_alu_sliced
  import jeff_alu_sliced_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             co,
  output logic             aeqb
`ifdef JEFF_ALU_SLICED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICES = WIDTH / SLICE_W;
  localparam int IDX_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [3:0]        r_s;
  logic              r_m;
  logic              r_carry;
  logic [IDX_W-1:0]  r_idx;
  logic [WIDTH-1:0]  r_f;
  logic              r_co;
  logic              r_aeqb;
  logic              r_out_valid;
  logic [3:0]        w_slice_f;
  logic              w_cout_n;
  logic              w_c3;
  logic [WIDTH-1:0]  w_f_next;
  logic              w_last;
  logic              w_accept;
  logic              w_release;

  alu_slice_4bit u_slice (
    .a      (r_a[r_idx*SLICE_W +: SLICE_W]),
    .b      (r_b[r_idx*SLICE_W +: SLICE_W]),
    .s      (r_s),
    .m      (r_m),
    .cin_n  (r_carry),
    .f      (w_slice_f),
    .cout_n (w_cout_n),
    .c3     (w_c3)
  );

  assign in_ready  = (r_state == ST_IDLE) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_release = (r_state == ST_DONE) && out_ready;
  assign w_last    = (r_idx == LAST_IDX);
  assign out_valid = r_out_valid;
  assign f         = r_f;
  assign co        = r_co;
  assign aeqb      = r_aeqb;

  // Result word with the current slice merged in.
  always_comb begin
    w_f_next = r_f;
    w_f_next[r_idx*SLICE_W +: SLICE_W] = w_slice_f;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_next = ST_RUN;
      ST_RUN:  if (w_last)    w_state_next = ST_DONE;
      ST_DONE: if (w_release) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  // Operand capture, slice sequencing and result/flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_s         <= '0;
      r_m         <= 1'b0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_f         <= '0;
      r_co        <= 1'b1;
      r_aeqb      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_s     <= s;
            r_m     <= m;
            r_carry <= ci;
            r_idx   <= '0;
          end
        end
        ST_RUN: begin
          r_f     <= w_f_next;
          // Logic mode breaks the carry chain; carry stays "none".
          r_carry <= r_m ? 1'b1 : w_cout_n;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_co        <= r_m ? 1'b1 : w_cout_n;
            r_aeqb      <= &w_f_next;
            r_out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (w_release) begin
            r_out_valid <= 1'b0;
            r_aeqb      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef JEFF_ALU_SLICED_OVF_EN
  logic r_ovf;
  assign ovf = r_ovf;

  // Signed overflow: carry into MSB differs from carry out of MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == ST_IDLE && w_accept) begin
      r_ovf <= 1'b0;
    end else if (r_state == ST_RUN && w_last) begin
      r_ovf <= r_m ? 1'b0 : (w_c3 ^ ~w_cout_n);
    end
  end
`endif

endmodule

// File: tb/tb_jeff_alu_sliced.sv
// Self-checking bench for jeff_alu_sliced (WIDTH=16) against a word-level
// '181 model.
module tb_jeff_alu_sliced;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   s;
  logic         m;
  logic         ci;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] f;
  logic         co;
  logic         aeqb;
`ifdef JEFF_ALU_SLICED_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_f;
  logic         exp_co;
  logic         exp_aeqb;
  logic         exp_ovf;
  logic         chk_en = 1'b0;

  always #5 clk = ~clk;

  jeff_alu_sliced #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .m         (m),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .co        (co),
    .aeqb      (aeqb)
`ifdef JEFF_ALU_SLICED_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Word-level '181: arithmetic result is X + Y + carry, logic is ~(X ^ Y).
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic [3:0] ts, input logic tm, input logic tci,
                       output logic [W-1:0] rf, output logic rco,
                       output logic raeqb, output logic rovf);
    logic [W-1:0] x, y;
    logic [W:0]   sum;
    logic [W-1:0] low;
    x = ta | (tb_ & {W{ts[0]}}) | (~tb_ & {W{ts[1]}});
    y = (ta & ~tb_ & {W{ts[2]}}) | (ta & tb_ & {W{ts[3]}});
    sum = {1'b0, x} + {1'b0, y} + (W+1)'(!tci);
    low = {1'b0, x[W-2:0]} + {1'b0, y[W-2:0]} + W'(!tci);
    if (tm) begin
      rf   = ~(x ^ y);
      rco  = 1'b1;
      rovf = 1'b0;
    end else begin
      rf   = sum[W-1:0];
      rco  = ~sum[W];
      rovf = low[W-1] ^ sum[W];
    end
    raeqb = &rf;
  endtask

  // Every cycle a result is presented, it must match the model.
  always @(negedge clk) begin
    if (!rst && chk_en && out_valid) begin
      check("f", 32'(f), 32'(exp_f));
      check("co", 32'(co), 32'(exp_co));
      check("aeqb", 32'(aeqb), 32'(exp_aeqb));
`ifdef JEFF_ALU_SLICED_OVF_EN
      check("ovf", 32'(ovf), 32'(exp_ovf));
`endif
    end
  end

  // Issue an op, time its latency, hold off the consumer for 'hold' cycles
  // while offering junk operands, then take the result.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [3:0] ts, input logic tm, input logic tci,
                        input int hold, input bit use_lit,
                        input logic [W-1:0] lf, input logic lco, input logic laeqb);
    int cnt;
    @(negedge clk);
    a = ta; b = tb_; s = ts; m = tm; ci = tci; in_valid = 1'b1;
    model(ta, tb_, ts, tm, tci, exp_f, exp_co, exp_aeqb, exp_ovf);
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      check("in_ready_busy", 32'(in_ready), 32'd0);
      @(negedge clk);
      cnt++;
    end
    check("latency", 32'(cnt), 32'd4);
    if (use_lit) begin
      check("lit_f", 32'(f), 32'(lf));
      check("lit_co", 32'(co), 32'(lco));
      check("lit_aeqb", 32'(aeqb), 32'(laeqb));
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom); s = 4'($urandom);
      m = 1'($urandom); ci = 1'($urandom);
      check("in_ready_done", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("out_valid_held", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_release", 32'(in_ready), 32'd1);
    check("out_valid_after_release", 32'(out_valid), 32'd0);
    chk_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; s = '0; m = 1'b0; ci = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_f", 32'(f), 32'd0);
    check("rst_co", 32'(co), 32'd1);
    check("rst_aeqb", 32'(aeqb), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed scenarios with hand-worked results.
    run_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b1, 0, 1'b1, 16'h0100, 1'b1, 1'b0);
    run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 0, 1'b1, 16'h0000, 1'b0, 1'b0);
    run_op(16'h1234, 16'h0000, 4'b1001, 1'b0, 1'b0, 0, 1'b1, 16'h1235, 1'b1, 1'b0);
    run_op(16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1, 0, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    run_op(16'h5A5B, 16'h5A5A, 4'b0110, 1'b0, 1'b1, 0, 1'b1, 16'h0000, 1'b0, 1'b0);
    run_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0, 0, 1'b1, 16'h0FF0, 1'b1, 1'b0);
    // Backpressure: consumer stalls 5 cycles with junk offered on the input.
    run_op(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 5, 1'b1, 16'h8000, 1'b1, 1'b0);

    // Reset while slice 2 is being computed.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; s = 4'b1001; m = 1'b0; ci = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_f", 32'(f), 32'd0);
    check("abort_co", 32'(co), 32'd1);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    run_op(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b1, 0, 1'b1, 16'h3333, 1'b1, 1'b0);

    // Randomized functions, modes, carries and stalls.
    for (int k = 0; k < 60; k++) begin
      run_op(W'($urandom), W'($urandom), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 2), 1'b0, '0, 1'b0, 1'b0);
    end
    // Operands that make A=B likely under subtract.
    for (int k = 0; k < 8; k++) begin
      logic [W-1:0] v;
      v = W'($urandom);
      run_op(v, v, 4'b0110, 1'b0, 1'b1, 1, 1'b0, '0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
